// File: rtl/pe_pkg.sv
// Shared definitions for the PE filter scheduler: FSM state encoding and
// default sizing of the filter/ifmap scratchpads.
package pe_pkg;

  localparam int DEF_CONFIG_BIT = 4;
  localparam int DEF_NUM_OF_REG = 16;
  localparam int DEF_ADDR_W     = $clog2(DEF_NUM_OF_REG);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    FLUSH = 3'd2,
    PSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/filt_base_cnt.sv
// Filter-base counter: tracks the filter index f inside the filter scratchpad
// and its base word address f*filter_size. 'last' flags the final filter.
module filt_base_cnt
  import pe_pkg::*;
#(
  parameter int CONFIG_BIT = DEF_CONFIG_BIT,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step,
  input  logic [CONFIG_BIT-1:0] filter_size,
  input  logic [ADDR_W:0]       num_filters,
  output logic [ADDR_W:0]       base,
  output logic                  last
);

  localparam logic [ADDR_W:0] A_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_f;
  logic [ADDR_W:0] r_base;

  // filter index and base address move together; clear has priority over step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f    <= '0;
      r_base <= '0;
    end else if (clear) begin
      r_f    <= '0;
      r_base <= '0;
    end else if (step) begin
      r_f    <= r_f + A_ONE;
      r_base <= r_base + (ADDR_W+1)'(filter_size);
    end
  end

  assign base = r_base;
  assign last = (r_f == (num_filters - A_ONE));

endmodule

// File: rtl/pe_filter_scheduler.sv
// PE filter scheduler: one start pulse walks every filter in the filter
// scratchpad over every valid ifmap window, issuing one MAC per tap, one flush
// cycle for the scratchpad read latency, then a valid/ready partial-sum hand-off.
// Optional feature macro: SCHED_PERF_CNT_EN adds the stall_cnt output.
module pe_filter_scheduler
  import pe_pkg::*;
#(
  parameter int CONFIG_BIT = DEF_CONFIG_BIT,
  parameter int NUM_OF_REG = DEF_NUM_OF_REG,
  parameter int ADDR_W     = $clog2(NUM_OF_REG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CONFIG_BIT-1:0] filter_size,
  input  logic [CONFIG_BIT-1:0] stride,
  input  logic [ADDR_W:0]       if_len,
  output logic                  busy,
  output logic [ADDR_W-1:0]     filt_addr,
  output logic [ADDR_W-1:0]     if_addr,
  output logic                  mac_en,
  output logic                  acc_clr,
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic                  done,
  output logic                  err
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // one spare bit so the window-bound test can never wrap
  localparam int              CW     = ADDR_W + 2;
  localparam logic [ADDR_W:0] A_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CW-1:0]   NREG_C = CW'(NUM_OF_REG);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CONFIG_BIT-1:0] r_fs;
  logic [CONFIG_BIT-1:0] r_stride;
  logic [ADDR_W:0]       r_len;
  logic [ADDR_W:0]       r_nf;
  logic [ADDR_W:0]       r_k;
  logic [ADDR_W:0]       r_win;
  logic                  r_err;
  logic [ADDR_W:0]       w_base;
  logic [ADDR_W:0]       w_nf;
  logic [ADDR_W:0]       w_fs_a;
  logic                  w_last;
  logic                  w_cfg_err;
  logic                  w_fits;
  logic [CW-1:0]         w_win_nxt;
  logic [CW-1:0]         w_end_nxt;
  logic                  w_latch;
  logic                  w_cnt_clear;
  logic                  w_cnt_step;
  logic                  w_k_clr;
  logic                  w_k_inc;
  logic                  w_win_clr;
  logic                  w_win_step;

  filt_base_cnt #(
    .CONFIG_BIT (CONFIG_BIT),
    .ADDR_W     (ADDR_W)
  ) u_filt_base_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_cnt_clear),
    .step        (w_cnt_step),
    .filter_size (r_fs),
    .num_filters (r_nf),
    .base        (w_base),
    .last        (w_last)
  );

  assign w_fs_a    = (ADDR_W+1)'(r_fs);
  assign w_win_nxt = CW'(r_win) + CW'(r_stride);
  assign w_end_nxt = w_win_nxt + CW'(r_fs);
  assign w_fits    = (w_end_nxt <= CW'(r_len));

  // validate the raw config and derive the filter count; only used when start is accepted
  always_comb begin
    w_cfg_err = 1'b0;
    w_nf      = '0;
    if (filter_size == '0) begin
      w_cfg_err = 1'b1;
    end else if (CW'(filter_size) > NREG_C) begin
      w_cfg_err = 1'b1;
    end else if (stride == '0) begin
      w_cfg_err = 1'b1;
    end else if (CW'(filter_size) > CW'(if_len)) begin
      w_cfg_err = 1'b1;
    end else begin
      w_cfg_err = 1'b0;
    end
    if (filter_size == '0) begin
      w_nf = '0;
    end else begin
      w_nf = (ADDR_W+1)'(NUM_OF_REG / int'(filter_size));
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state and counter control
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_step  = 1'b0;
    w_k_clr     = 1'b0;
    w_k_inc     = 1'b0;
    w_win_clr   = 1'b0;
    w_win_step  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_cnt_clear = 1'b1;
          w_k_clr     = 1'b1;
          w_win_clr   = 1'b1;
          if (w_cfg_err) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = MAC;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MAC: begin
        // k stays on the last tap so FLUSH/PSUM hold the final addresses
        if (r_k == (w_fs_a - A_ONE)) begin
          w_state_nxt = FLUSH;
        end else begin
          w_k_inc = 1'b1;
        end
      end
      FLUSH: begin
        w_state_nxt = PSUM;
      end
      PSUM: begin
        if (psum_ready) begin
          w_k_clr = 1'b1;
          if (w_last) begin
            w_cnt_clear = 1'b1;
            if (w_fits) begin
              w_win_step  = 1'b1;
              w_state_nxt = MAC;
            end else begin
              w_win_clr   = 1'b1;
              w_state_nxt = DONE;
            end
          end else begin
            w_cnt_step  = 1'b1;
            w_state_nxt = MAC;
          end
        end else begin
          w_state_nxt = PSUM;
        end
      end
      DONE: begin
        w_cnt_clear = 1'b1;
        w_k_clr     = 1'b1;
        w_win_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // latched configuration and sticky error, refreshed only on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fs     <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_nf     <= '0;
      r_err    <= 1'b0;
    end else if (w_latch) begin
      r_fs     <= filter_size;
      r_stride <= stride;
      r_len    <= if_len;
      r_nf     <= w_nf;
      r_err    <= w_cfg_err;
    end
  end

  // tap counter k
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= '0;
    end else if (w_k_clr) begin
      r_k <= '0;
    end else if (w_k_inc) begin
      r_k <= r_k + A_ONE;
    end
  end

  // window start address w*stride, stepped only when the next window fits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
    end else if (w_win_clr) begin
      r_win <= '0;
    end else if (w_win_step) begin
      r_win <= w_win_nxt[ADDR_W:0];
    end
  end

  // output decode from registered state and counters
  always_comb begin
    busy       = (r_state != IDLE);
    mac_en     = (r_state == MAC);
    acc_clr    = (r_state == MAC) && (r_k == '0);
    psum_valid = (r_state == PSUM);
    done       = (r_state == DONE);
    err        = r_err;
    filt_addr  = ADDR_W'(w_base + r_k);
    if_addr    = ADDR_W'(r_win + r_k);
  end

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  // saturating count of PSUM cycles stalled by the psum buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_latch) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == PSUM) && !psum_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pe_filter_scheduler.sv
// Self-checking bench for pe_filter_scheduler: table of directed configs with
// hand-computed pass results, a nested-loop reference for every MAC address,
// plus hand-written stall, mid-pass reset and ignored-restart sequences.
module tb_pe_filter_scheduler;
  import pe_pkg::*;

  localparam int AW = DEF_ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          psum_ready = 1'b1;
  logic [3:0]    filter_size = 4'd0;
  logic [3:0]    stride = 4'd0;
  logic [AW:0]   if_len = '0;
  logic          busy, mac_en, acc_clr, psum_valid, done, err;
  logic [AW-1:0] filt_addr, if_addr;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  fs;
    logic [3:0]  st;
    logic [AW:0] len;
    int          psums;
    int          done_cyc;   // negedges after the start edge until done is seen
    int          last_f0;    // filt_addr at tap 0 of the last psum
    int          last_i0;    // if_addr at tap 0 of the last psum
    bit          err;
  } vec_t;

  vec_t vecs[9];

  pe_filter_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .filter_size (filter_size),
    .stride      (stride),
    .if_len      (if_len),
    .busy        (busy),
    .filt_addr   (filt_addr),
    .if_addr     (if_addr),
    .mac_en      (mac_en),
    .acc_clr     (acc_clr),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .done        (done),
    .err         (err)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // run one pass; stall_n holds psum_ready low for the first psum, poke re-pulses start mid-pass
  task automatic run_pass(input string tag, input vec_t v, input int stall_n, input bit poke);
    int cyc, psums, first_mac, done_cyc, bad, mw, mf, mk, nf, lf0, li0, stall_left, vfirst;
    int stall_seen;
    logic [AW-1:0] hold_f, hold_i;
    bit in_psum;
    cyc = 0; psums = 0; first_mac = -1; done_cyc = -1; bad = 0;
    mw = 0; mf = 0; mk = 0; lf0 = -1; li0 = -1; stall_left = stall_n; vfirst = 0;
    stall_seen = 0; hold_f = '0; hold_i = '0; in_psum = 1'b0;
    nf = (v.fs == 4'd0) ? 0 : DEF_NUM_OF_REG / int'(v.fs);

    @(negedge clk);
    filter_size = v.fs; stride = v.st; if_len = v.len; start = 1'b1; psum_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_err_after_start"}, int'(err), int'(v.err));

    while (done_cyc < 0 && cyc < 3000) begin
      if (poke && cyc == 5) begin
        start = 1'b1; filter_size = 4'd2; stride = 4'd3; if_len = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (psum_valid && stall_left > 0) begin
        psum_ready = 1'b0;
        stall_left--;
      end else begin
        psum_ready = 1'b1;
      end

      if (mac_en && psum_valid) bad++;
      if (mac_en) begin
        if (v.err) begin
          bad++;
        end else begin
          if (int'(filt_addr) != mf * int'(v.fs) + mk) bad++;
          if (int'(if_addr) != mw * int'(v.st) + mk) bad++;
          if (acc_clr != (mk == 0)) bad++;
          if (acc_clr) begin
            lf0 = int'(filt_addr);
            li0 = int'(if_addr);
          end
          if (first_mac < 0) first_mac = cyc;
          mk++;
        end
      end else if (acc_clr) begin
        bad++;
      end

      if (psum_valid) begin
        if (!in_psum) begin
          hold_f = filt_addr; hold_i = if_addr; in_psum = 1'b1;
          if (mk != int'(v.fs)) bad++;
        end else if (filt_addr != hold_f || if_addr != hold_i) begin
          bad++;
        end
        if (psums == 0) vfirst++;
        if (psum_ready) begin
          psums++; in_psum = 1'b0; mk = 0; mf++;
          if (mf == nf) begin
            mf = 0; mw++;
          end
        end else begin
          stall_seen++;
        end
      end

      if (done) begin
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end

    chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    chk({tag, "_psums"}, psums, v.psums);
    chk({tag, "_done_cycle"}, done_cyc, v.done_cyc);
    chk({tag, "_first_mac"}, first_mac, v.err ? -1 : 1);
    chk({tag, "_seq_errors"}, bad, 0);
    chk({tag, "_last_filt0"}, lf0, v.last_f0);
    chk({tag, "_last_if0"}, li0, v.last_i0);
    chk({tag, "_err_at_done"}, int'(err), int'(v.err));
    if (stall_n > 0) begin
      chk({tag, "_valid_cycles"}, vfirst, stall_n + 1);
      chk({tag, "_stall_seen"}, stall_seen, stall_n);
    end
`ifdef SCHED_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, int'(stall_cnt), stall_n);
`endif
    @(negedge clk);
    psum_ready = 1'b1;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_err_sticky"}, int'(err), int'(v.err));
  endtask

  initial begin
    vec_t vs;
    // fs, stride, if_len, psums, done_cyc, last_f0, last_i0, err
    vecs[0] = '{4'd4,  4'd1, 5'd6,  12, 73,  12, 2,  1'b0};
    vecs[1] = '{4'd5,  4'd2, 5'd9,  9,  64,  10, 4,  1'b0};
    vecs[2] = '{4'd0,  4'd1, 5'd8,  0,  1,   -1, -1, 1'b1};
    vecs[3] = '{4'd7,  4'd1, 5'd5,  0,  1,   -1, -1, 1'b1};
    vecs[4] = '{4'd2,  4'd0, 5'd8,  0,  1,   -1, -1, 1'b1};
    vecs[5] = '{4'd15, 4'd1, 5'd16, 2,  35,  0,  1,  1'b0};
    vecs[6] = '{4'd1,  4'd3, 5'd16, 96, 289, 15, 15, 1'b0};
    vecs[7] = '{4'd8,  4'd8, 5'd16, 4,  41,  8,  8,  1'b0};
    vecs[8] = '{4'd3,  4'd2, 5'd3,  5,  26,  12, 0,  1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mac_en", int'(mac_en), 0);
    chk("reset_psum_valid", int'(psum_valid), 0);
    chk("reset_done_err", int'({done, err, acc_clr}), 0);
    chk("reset_addrs", int'({filt_addr, if_addr}), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_pass($sformatf("v%0d", i), vecs[i], 0, 1'b0);
      if (vecs[i].err) begin
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_err_hold", i), int'(err), 1);
      end
    end

    // three-cycle stall on the first psum
    vs = vecs[0];
    vs.done_cyc = vs.done_cyc + 3;
    run_pass("stall", vs, 3, 1'b0);

    // start re-pulsed with a different config mid-pass
    run_pass("poke", vecs[1], 0, 1'b1);

    // asynchronous reset during the MAC phase of the second psum
    @(negedge clk);
    filter_size = 4'd4; stride = 4'd1; if_len = 5'd6; start = 1'b1; psum_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_pre_mac_en", int'(mac_en), 1);
    chk("rst_pre_filt_addr", int'(filt_addr), 5);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_mac_en", int'(mac_en), 0);
    chk("rst_mid_flags", int'({acc_clr, psum_valid, done, err}), 0);
    chk("rst_mid_addrs", int'({filt_addr, if_addr}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_pass("after_rst", vecs[0], 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_filter_scheduler.md
Name: pe_filter_scheduler

Overview:
Sequencing controller for the CNN PE datapath. It walks every filter packed in the PE filter scratchpad across every valid ifmap window, using an internal filter-base counter. It drives scratchpad read addresses, MAC enable/accumulator clear, and a valid/ready partial-sum handshake toward the psum buffer. One start pulse runs one full convolution pass for the latched configuration.

Parameters:
CONFIG_BIT, 4, width of filter_size and stride config fields
NUM_OF_REG, 16, filter scratchpad depth (words); also ifmap scratchpad depth
ADDR_W, $clog2(NUM_OF_REG), scratchpad address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin pass; sampled only in IDLE
filter_size  in  CONFIG_BIT  taps per filter
stride  in  CONFIG_BIT  window step in ifmap words
if_len  in  ADDR_W+1  valid ifmap words (1..NUM_OF_REG)
busy  out  1  high in any state other than IDLE
filt_addr  out  ADDR_W  filter scratchpad read address
if_addr  out  ADDR_W  ifmap scratchpad read address
mac_en  out  1  issue one MAC this cycle
acc_clr  out  1  with mac_en: load product instead of accumulate
psum_valid  out  1  partial sum ready for psum buffer
psum_ready  in  1  psum buffer accepts
done  out  1  one-cycle pulse at end of pass
err  out  1  config error; sticky until next accepted start

Behaviour:
- Reset (async, immediate, also mid-pass): state IDLE. All outputs 0; internal counters 0. In-flight psum is discarded.
- On start in IDLE: latch filter_size, stride, if_len; clear err. Compute num_filters = NUM_OF_REG / filter_size (floor, width ADDR_W+1).
- Config error if filter_size==0, filter_size>NUM_OF_REG, stride==0, or filter_size>if_len. On error: go to DONE, set err=1, no mac_en.
- States: IDLE -> MAC -> FLUSH -> PSUM -> (MAC | DONE) -> IDLE.
- MAC: one cycle per tap k = 0..filter_size-1, with mac_en=1.
  - filt_addr = base + k, where base = f*filter_size from the base counter.
  - if_addr = w*stride + k.
  - acc_clr = (k==0).
- FLUSH: exactly one cycle. Covers the synchronous scratchpad read latency. mac_en=0.
- PSUM: psum_valid=1 until psum_ready sampled high. Addresses are held; mac_en=0.
- On handshake:
  - If f < num_filters-1: f++, base += filter_size, go to MAC.
  - Otherwise: f=0, base=0, w++.
    - If (w+1)*stride + filter_size <= if_len, go to MAC.
    - Otherwise go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy: ignored.
- Config inputs changing mid-pass: no effect (latched values are used).
- Address arithmetic is computed at ADDR_W+1 bits. The window bound guarantees no wrap.
- Throughput with psum_ready held high: each psum takes filter_size+2 cycles.

Optional Feature:
SCHED_PERF_CNT_EN
- Defined: adds output stall_cnt (16 bits). It counts cycles in PSUM with psum_ready=0, cleared on accepted start, and saturates at 0xFFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pe_pkg: state enum (IDLE, MAC, FLUSH, PSUM, DONE), CONFIG_BIT/NUM_OF_REG defaults, ADDR_W derivation.
- One sub-module: filt_base_cnt.
  - Inputs: clk, rst, clear, step, filter_size, num_filters.
  - Outputs: base, last (f==num_filters-1).
  - The top FSM owns the tap (k) and window (w) counters.

Test Plan:
- filter_size=4, stride=1, if_len=6, psum_ready=1 -> num_filters=4, 3 windows, 12 psums. First psum uses filt_addr 0..3, if_addr 0..3, acc_clr only on first. done exactly 72 cycles after first mac_en; err=0.
- filter_size=5, stride=2, if_len=9 -> num_filters=3, windows w=0..2, 9 psums. Last psum uses filt_addr 10..14, if_addr 4..8.
- psum_ready low for 3 cycles at first psum -> psum_valid held 4 cycles, addresses stable, no mac_en. With SCHED_PERF_CNT_EN, stall_cnt=3 at done.
- filter_size=0 (and separately filter_size=7, if_len=5) -> no mac_en, done pulse 1 cycle after start, err=1 until next valid start.
- rst asserted during MAC of second psum -> same edge: outputs 0, IDLE. A new start runs a full, correct pass.
- start re-pulsed and filter_size changed mid-pass -> ignored; psum count and addresses match the original config.
